hist_table_ram: RTL

Parametrised single-clock 1W1R storage array for the OoO front end's history and predictor tables (local history, pattern tables). It is the successor to the fixed 256x8 table macro model. It adds configurable width and depth, per-byte write masking, and a post-reset clear sweep. It also adds defined read-during-write behaviour with optional same-cycle forwarding. It sits between the branch-predictor lookup and update paths: lookup issues reads, retire/update issues writes.

---
 rtl/hist_table_ram.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hist_table_ram.sv
// hist_table_ram: parametrised single-clock 1W1R storage array for predictor and
// history tables. After reset a sweep writes INIT_VALUE to every entry before
// requests are accepted.
//
// Ports:
//   i_clk      clock, all logic on the rising edge
//   i_rst      asynchronous active-high reset
//   o_ready    high once the clear sweep has finished
//   i_rd_en    read request
//   i_rd_addr  read address
//   o_rdata    registered read data; holds its value when no read is issued
//   o_rvalid   one-cycle pulse when o_rdata was updated
//   i_wr_en    write request
//   i_wr_addr  write address
//   i_wr_mask  byte enables; bit i covers wdata[8i+7:8i]
//   i_wdata    write data
//
// Build option:
//   HIST_TABLE_BYPASS_EN  defined   -> a colliding read returns the merged write value
//                         undefined -> a colliding read returns the pre-write value
//
// Addresses >= DEPTH are out of range: writes are dropped and reads return INIT_VALUE.
module hist_table_ram #(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter int unsigned            ADDR_WIDTH = 8,
   parameter int unsigned            DEPTH      = 1 << ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   output logic                      o_ready,
   input  logic                      i_rd_en,
   input  logic [ADDR_WIDTH-1:0]     i_rd_addr,
   output logic [DATA_WIDTH-1:0]     o_rdata,
   output logic                      o_rvalid,
   input  logic                      i_wr_en,
   input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH/8-1:0]   i_wr_mask,
   input  logic [DATA_WIDTH-1:0]     i_wdata
);

   localparam int unsigned           NumBytes = DATA_WIDTH / 8;
   // One extra bit so DEPTH == 2^ADDR_WIDTH is representable in the range compare.
   localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {StClear, StRun} state_e;

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_rvalid;

   logic                    w_run;
   logic                    w_clear_we;
   logic                    w_rd_in_range;
   logic                    w_wr_in_range;
   logic                    w_rd_fire;
   logic                    w_wr_fire;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StClear;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: leave CLEAR once the last entry is written
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StClear: if (r_cnt == LastIdx) w_state_nxt = StRun;
         StRun:   w_state_nxt = StRun;
         default: w_state_nxt = StClear;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_run      = 1'b0;
      w_clear_we = 1'b0;
      unique case (r_state)
         StClear: w_clear_we = 1'b1;
         StRun:   w_run      = 1'b1;
         default: w_clear_we = 1'b1;
      endcase
   end

   assign o_ready = w_run;

   // Sweep counter; only advances while clearing
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_clear_we) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_rd_in_range = ({1'b0, i_rd_addr} < DepthExt);
   assign w_wr_in_range = ({1'b0, i_wr_addr} < DepthExt);
   assign w_rd_fire     = w_run & i_rd_en;
   assign w_wr_fire     = w_run & i_wr_en & w_wr_in_range;

   // Storage array; not reset, the sweep initialises it
   always_ff @(posedge i_clk) begin
      if (w_clear_we) begin
         r_mem[r_cnt] <= INIT_VALUE;
      end else if (w_wr_fire) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (i_wr_mask[b]) r_mem[i_wr_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // Read word selection, including optional same-cycle forwarding
   always_comb begin
      w_rd_word = INIT_VALUE;
      if (w_rd_in_range) begin
         w_rd_word = r_mem[i_rd_addr];
`ifdef HIST_TABLE_BYPASS_EN
         if (w_wr_fire && (i_wr_addr == i_rd_addr)) begin
            for (int b = 0; b < NumBytes; b++) begin
               if (i_wr_mask[b]) w_rd_word[8*b +: 8] = i_wdata[8*b +: 8];
            end
         end
`endif
      end
   end

   // Registered read port
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_fire;
         if (w_rd_fire) r_rdata <= w_rd_word;
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule
